// File: rtl/up_down_ramp_ctrl.sv
// up_down_ramp_ctrl: sequencer for the shared up/down counter.
// Takes "ramp to target" or "clear" commands over valid/ready and walks the
// counter one step every STEP_DIV cycles toward the target. Each step
// decision is made from the counter read-back (cnt_q), so if something else
// moves the counter, the controller still heads the right way.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a command; equal-target commands complete here
// CLEAR | cnt_clr is high for this one cycle
// STEP  | cnt_en is high for this one cycle; direction already latched
// WAIT  | STEP_DIV-1 cycles of settling; the last one decides what next
module up_down_ramp_ctrl #(
  parameter int WIDTH    = 8,
  parameter int STEP_DIV = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_clear,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic             cmd_abort,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_en,
  output logic             cnt_up_down,
  output logic             cnt_clr,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    STEP  = 2'd2,
    WAIT  = 2'd3
  } state_t;

  // STEP takes 1 cycle and WAIT takes STEP_DIV-1 cycles. The divider counts
  // down from STEP_DIV-2 to 0, so the period is exactly STEP_DIV cycles.
  localparam int DIV_W = $clog2(STEP_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(STEP_DIV - 2);

  state_t           state;
  logic [WIDTH-1:0] target_r;
  logic [DIV_W-1:0] div_r;

  // Single registered FSM. Every output is a registered decode of the next
  // state, so it lines up with the state it describes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      target_r    <= '0;
      div_r       <= '0;
      cnt_en      <= 1'b0;
      cnt_up_down <= 1'b0;
      cnt_clr     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      cmd_ready   <= 1'b1;
    end else begin
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          // cmd_abort has no meaning here. If it arrives together with a
          // command, the command wins.
          if (cmd_valid) begin
            target_r <= cmd_target;
            if (cmd_clear) begin
              state     <= CLEAR;
              cnt_clr   <= 1'b1;
              busy      <= 1'b1;
              cmd_ready <= 1'b0;
            end else if (cmd_target == cnt_q) begin
              done <= 1'b1;
            end else begin
              state       <= STEP;
              cnt_en      <= 1'b1;
              cnt_up_down <= (cmd_target > cnt_q);
              busy        <= 1'b1;
              cmd_ready   <= 1'b0;
            end
          end
        end
        CLEAR: begin
          // A clear cannot be aborted. It always finishes with done.
          state     <= IDLE;
          done      <= 1'b1;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        STEP: begin
          // The enable pulse in this cycle still lands on the counter,
          // even if an abort is sampled at the same edge.
          if (cmd_abort) begin
            state     <= IDLE;
            aborted   <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            state <= WAIT;
            div_r <= DIV_LOAD;
          end
        end
        WAIT: begin
          if (cmd_abort) begin
            state     <= IDLE;
            aborted   <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else if (div_r == '0) begin
            if (cnt_q == target_r) begin
              state     <= IDLE;
              done      <= 1'b1;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
            end else begin
              state       <= STEP;
              cnt_en      <= 1'b1;
              cnt_up_down <= (target_r > cnt_q);
            end
          end else begin
            div_r <= div_r - DIV_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
